// File: rtl/emc_pht_capture.sv
// Phonic-wheel tooth capture unit.
//
// Synchronizes and filters the raw tooth input, then measures the time between selected edges in
// prescaled clock ticks. Also counts teeth since the last missing-tooth gap and flags a stall
// when the period counter would overflow.
//
// Ports:
//   pht_clock_i      system clock, rising edge
//   pht_reset_i      asynchronous active-low reset
//   pht_pin_i        raw tooth signal (asynchronous)
//   pht_en_i         block enable
//   pht_edge_sel_i   0 = rising edges, 1 = falling edges
//   pht_prescale_i   counter tick every 2^p clocks
//   pht_irq_clr_i    one-cycle clear of irq and ovf
//   pht_period_o     last captured period in ticks
//   pht_valid_o      one-cycle pulse per capture
//   pht_gap_o        one-cycle pulse with valid when the capture is a gap
//   pht_tooth_cnt_o  teeth since last gap
//   pht_ovf_o        sticky stall flag
//   pht_irq_o        sticky interrupt request
module emc_pht_capture #(
  parameter int unsigned FILT_LEN = 3,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             pht_clock_i,
  input  logic             pht_reset_i,
  input  logic             pht_pin_i,
  input  logic             pht_en_i,
  input  logic             pht_edge_sel_i,
  input  logic [2:0]       pht_prescale_i,
  input  logic             pht_irq_clr_i,
  output logic [CNT_W-1:0] pht_period_o,
  output logic             pht_valid_o,
  output logic             pht_gap_o,
  output logic [7:0]       pht_tooth_cnt_o,
  output logic             pht_ovf_o,
  output logic             pht_irq_o
);

  typedef enum logic [1:0] {StIdle, StArm, StMeas} state_e;

  state_e               state_q, state_d;
  logic [1:0]           sync_q;
  logic [FILT_LEN-1:0]  filt_sh_q;
  logic                 filt_q, filt_d;
  logic                 filt_dly_q;
  logic [6:0]           pre_q, pre_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CNT_W-1:0]     prev_q, prev_d;
  logic [CNT_W-1:0]     period_q, period_d;
  logic [7:0]           tooth_q, tooth_d;
  logic                 valid_q, valid_d;
  logic                 gap_q, gap_d;
  logic                 ovf_q, ovf_d;
  logic                 irq_q, irq_d;
  logic                 ovf_set, irq_set;

  logic                 sel_edge;
  logic [6:0]           pre_max;
  logic                 tick;
  logic [CNT_W:0]       cnt_sum;
  logic [CNT_W:0]       gap_thresh;
  logic                 is_gap;

  // Filtered level only moves when the whole window agrees on the opposite level.
  always_comb begin
    filt_d = filt_q;
    if (&filt_sh_q) begin
      filt_d = 1'b1;
    end else if (~|filt_sh_q) begin
      filt_d = 1'b0;
    end
  end

  assign sel_edge = pht_edge_sel_i ? (~filt_q & filt_dly_q) : (filt_q & ~filt_dly_q);

  assign pre_max    = 7'((8'd1 << pht_prescale_i) - 8'd1);
  assign tick       = (pre_q == pre_max);
  assign cnt_sum    = {1'b0, cnt_q} + {{CNT_W{1'b0}}, tick};
  // Threshold is 1.5x the previous period, kept one bit wider so it cannot wrap.
  assign gap_thresh = {1'b0, prev_q} + {2'b00, prev_q[CNT_W-1:1]};
  assign is_gap     = (prev_q != '0) && (cnt_sum > gap_thresh);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pre_d    = pre_q;
    prev_d   = prev_q;
    tooth_d  = tooth_q;
    period_d = period_q;
    valid_d  = 1'b0;
    gap_d    = 1'b0;
    ovf_set  = 1'b0;
    irq_set  = 1'b0;

    if (!pht_en_i) begin
      // Any in-flight measurement is dropped; period and flags are kept.
      state_d = StIdle;
      cnt_d   = '0;
      pre_d   = '0;
      prev_d  = '0;
      tooth_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StArm;
          cnt_d   = '0;
          pre_d   = '0;
          prev_d  = '0;
          tooth_d = '0;
        end
        StArm: begin
          cnt_d = '0;
          pre_d = '0;
          if (sel_edge) begin
            state_d = StMeas;
          end
        end
        StMeas: begin
          if (cnt_sum[CNT_W]) begin
            // Stall: counter would exceed its range, restart from a fresh arming edge.
            ovf_set = 1'b1;
            irq_set = 1'b1;
            prev_d  = '0;
            tooth_d = '0;
            cnt_d   = '0;
            pre_d   = '0;
            state_d = StArm;
          end else if (sel_edge) begin
            period_d = cnt_sum[CNT_W-1:0];
            valid_d  = 1'b1;
            irq_set  = 1'b1;
            cnt_d    = '0;
            pre_d    = '0;
            prev_d   = cnt_sum[CNT_W-1:0];
            if (is_gap) begin
              gap_d   = 1'b1;
              tooth_d = '0;
            end else begin
              tooth_d = tooth_q + 8'd1;
            end
          end else begin
            cnt_d = cnt_sum[CNT_W-1:0];
            pre_d = tick ? 7'd0 : pre_q + 7'd1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Setting a flag takes priority over a simultaneous clear.
  assign irq_d = irq_set | (irq_q & ~pht_irq_clr_i);
  assign ovf_d = ovf_set | (ovf_q & ~pht_irq_clr_i);

  always_ff @(posedge pht_clock_i or negedge pht_reset_i) begin
    if (!pht_reset_i) begin
      state_q    <= StIdle;
      sync_q     <= '0;
      filt_sh_q  <= '0;
      filt_q     <= 1'b0;
      filt_dly_q <= 1'b0;
      pre_q      <= '0;
      cnt_q      <= '0;
      prev_q     <= '0;
      period_q   <= '0;
      tooth_q    <= '0;
      valid_q    <= 1'b0;
      gap_q      <= 1'b0;
      ovf_q      <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= {sync_q[0], pht_pin_i};
      filt_sh_q  <= {filt_sh_q[FILT_LEN-2:0], sync_q[1]};
      filt_q     <= filt_d;
      filt_dly_q <= filt_q;
      pre_q      <= pre_d;
      cnt_q      <= cnt_d;
      prev_q     <= prev_d;
      period_q   <= period_d;
      tooth_q    <= tooth_d;
      valid_q    <= valid_d;
      gap_q      <= gap_d;
      ovf_q      <= ovf_d;
      irq_q      <= irq_d;
    end
  end

  assign pht_period_o    = period_q;
  assign pht_valid_o     = valid_q;
  assign pht_gap_o       = gap_q;
  assign pht_tooth_cnt_o = tooth_q;
  assign pht_ovf_o       = ovf_q;
  assign pht_irq_o       = irq_q;

endmodule

// File: tb/tb_emc_pht_capture.sv
// Self-checking bench for emc_pht_capture: drives tooth waveforms and checks every selected edge
// against a model that works from pin-edge times, the prescale divisor and the gap rule.
module tb_emc_pht_capture;

  localparam int unsigned FL = 3;
  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          pin;
  logic          en;
  logic          esel;
  logic [2:0]    pre;
  logic          clr;
  logic [CW-1:0] pht_period_o;
  logic          pht_valid_o;
  logic          pht_gap_o;
  logic [7:0]    pht_tooth_cnt_o;
  logic          pht_ovf_o;
  logic          pht_irq_o;

  emc_pht_capture #(
    .FILT_LEN(FL),
    .CNT_W   (CW)
  ) dut (
    .pht_clock_i    (clk),
    .pht_reset_i    (rst_n),
    .pht_pin_i      (pin),
    .pht_en_i       (en),
    .pht_edge_sel_i (esel),
    .pht_prescale_i (pre),
    .pht_irq_clr_i  (clr),
    .pht_period_o   (pht_period_o),
    .pht_valid_o    (pht_valid_o),
    .pht_gap_o      (pht_gap_o),
    .pht_tooth_cnt_o(pht_tooth_cnt_o),
    .pht_ovf_o      (pht_ovf_o),
    .pht_irq_o      (pht_irq_o)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  int unsigned vcount = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (pht_valid_o) vcount <= vcount + 1;

  int n_chk = 0;
  int n_pass = 0;

  // Reference model state
  bit          m_meas;
  int unsigned m_last;
  int unsigned m_prev;
  int unsigned m_tooth;
  int unsigned m_period;
  bit          m_irq;
  bit          m_ovf;
  int unsigned m_p;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
  endtask

  task automatic model_reset();
    m_meas = 0; m_last = 0; m_prev = 0; m_tooth = 0;
    m_period = 0; m_irq = 0; m_ovf = 0;
  endtask

  // Entered and left just after a negedge. Rising edge now, high for hi clocks, low for lo clocks.
  task automatic tooth(input int hi, input int lo, input bit clr_cap);
    bit          cap;
    bit          g;
    int unsigned per;
    cap = 0;
    g   = 0;
    pin = 1'b1;
    if (m_meas) begin
      per      = (cyc - m_last) >> m_p;
      g        = (m_prev != 0) && (per > m_prev + m_prev / 2);
      m_tooth  = g ? 0 : (m_tooth + 1) % 256;
      m_prev   = per;
      m_period = per;
      m_irq    = 1;
      cap      = 1;
    end else begin
      m_meas = 1;
    end
    m_last = cyc;
    repeat (FL + 3) @(posedge clk);
    @(negedge clk);
    if (clr_cap) clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    chk("valid", 32'(pht_valid_o), 32'(cap));
    chk("gap", 32'(pht_gap_o), 32'(g));
    chk("period", 32'(pht_period_o), 32'(m_period));
    chk("tooth_cnt", 32'(pht_tooth_cnt_o), 32'(m_tooth));
    chk("irq", 32'(pht_irq_o), 32'(m_irq));
    chk("ovf", 32'(pht_ovf_o), 32'(m_ovf));
    @(posedge clk);
    #1;
    chk("valid_pulse_end", 32'(pht_valid_o), 32'd0);
    chk("gap_pulse_end", 32'(pht_gap_o), 32'd0);
    repeat (hi - int'(FL) - 4) @(negedge clk);
    pin = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  // Drop enable mid-period, wiggle the pin while disabled, then re-enable with a new prescale.
  task automatic en_cycle(input int unsigned new_p);
    int unsigned v0;
    en = 1'b0;
    repeat (3) @(negedge clk);
    v0 = vcount;
    chk("dis_tooth_cnt", 32'(pht_tooth_cnt_o), 32'd0);
    chk("dis_period_held", 32'(pht_period_o), 32'(m_period));
    chk("dis_irq_held", 32'(pht_irq_o), 32'(m_irq));
    pin = 1'b1;
    repeat (20) @(negedge clk);
    pin = 1'b0;
    repeat (20) @(negedge clk);
    chk("dis_no_capture", vcount, v0);
    pre = 3'(new_p);
    en  = 1'b1;
    repeat (3) @(negedge clk);
    m_meas = 0; m_tooth = 0; m_prev = 0; m_p = new_p;
  endtask

  task automatic lone_clear();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    m_irq = 0;
    m_ovf = 0;
    chk("clr_irq", 32'(pht_irq_o), 32'd0);
    chk("clr_ovf", 32'(pht_ovf_o), 32'd0);
  endtask

  initial begin
    int unsigned tovf;
    int unsigned sp;
    rst_n = 1'b0; pin = 1'b0; en = 1'b0; esel = 1'b0; pre = 3'd0; clr = 1'b0;
    model_reset();
    m_p = 0;
    repeat (3) @(negedge clk);
    chk("rst_period", 32'(pht_period_o), 32'd0);
    chk("rst_valid", 32'(pht_valid_o), 32'd0);
    chk("rst_gap", 32'(pht_gap_o), 32'd0);
    chk("rst_tooth", 32'(pht_tooth_cnt_o), 32'd0);
    chk("rst_ovf", 32'(pht_ovf_o), 32'd0);
    chk("rst_irq", 32'(pht_irq_o), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    en = 1'b1;
    repeat (3) @(negedge clk);

    // Basic period: first edge arms, then 100-clock periods.
    repeat (5) tooth(20, 80, 0);

    // Missing tooth then normal tooth.
    tooth(20, 180, 0);
    tooth(20, 80, 0);
    tooth(20, 80, 0);

    // Two-clock glitch in the low phase must not produce a capture.
    tooth(20, 30, 0);
    pin = 1'b1;
    repeat (2) @(negedge clk);
    pin = 1'b0;
    repeat (15) begin
      @(posedge clk);
      #1;
      chk("glitch_no_valid", 32'(pht_valid_o), 32'd0);
    end
    @(negedge clk);
    repeat (30) @(negedge clk);
    tooth(20, 80, 0);

    // Clear coincident with a capture: set wins. Then a lone clear.
    tooth(20, 80, 1);
    lone_clear();
    repeat (20) @(negedge clk);

    // Prescale 3: 800 and 805 clock spacing both give 100.
    en_cycle(3);
    repeat (3) tooth(20, 780, 0);
    repeat (2) tooth(20, 785, 0);

    // Randomized spacing with occasional missing teeth.
    en_cycle($urandom_range(0, 2));
    repeat (16) begin
      sp = $urandom_range(40, 260);
      if ($urandom_range(0, 4) == 0) sp = sp * 2;
      tooth(20, int'(sp) - 20, 0);
    end

    // Stall: arm, then no edges until the counter runs out.
    en_cycle(0);
    tooth(20, 20, 0);
    tovf = m_last + FL + 4 + 65536;
    while (cyc < tovf - 1) begin
      @(posedge clk);
      #1;
    end
    chk("ovf_not_yet", 32'(pht_ovf_o), 32'd0);
    @(posedge clk);
    #1;
    chk("ovf_set", 32'(pht_ovf_o), 32'd1);
    chk("ovf_irq_set", 32'(pht_irq_o), 32'd1);
    chk("ovf_tooth_clr", 32'(pht_tooth_cnt_o), 32'd0);
    m_ovf = 1; m_irq = 1; m_meas = 0; m_prev = 0; m_tooth = 0;
    @(negedge clk);
    tooth(20, 80, 0);
    tooth(20, 80, 0);
    tooth(20, 80, 0);
    lone_clear();

    // Asynchronous reset mid-period clears everything without a clock edge.
    tooth(20, 80, 0);
    repeat (10) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("areset_period", 32'(pht_period_o), 32'd0);
    chk("areset_valid", 32'(pht_valid_o), 32'd0);
    chk("areset_gap", 32'(pht_gap_o), 32'd0);
    chk("areset_tooth", 32'(pht_tooth_cnt_o), 32'd0);
    chk("areset_ovf", 32'(pht_ovf_o), 32'd0);
    chk("areset_irq", 32'(pht_irq_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    tooth(20, 80, 0);
    tooth(20, 80, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
